// File: rtl/eth_frame_source.sv
// Replays a preloaded payload buffer as one Ethernet header followed by an
// AXI-stream payload, with backpressure, byte-accurate last-beat tkeep and abort.
module eth_frame_source #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,

    input  logic                  start,
    input  logic [47:0]           dest_mac,
    input  logic [47:0]           src_mac,
    input  logic [15:0]           eth_type,
    input  logic [15:0]           byte_len,
    input  logic                  abort,

    output logic                  m_eth_hdr_valid,
    input  logic                  m_eth_hdr_ready,
    output logic [47:0]           m_eth_dest_mac,
    output logic [47:0]           m_eth_src_mac,
    output logic [15:0]           m_eth_type,
    output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
    output logic                  m_eth_payload_axis_tvalid,
    input  logic                  m_eth_payload_axis_tready,
    output logic                  m_eth_payload_axis_tlast,
    output logic                  m_eth_payload_axis_tuser,

    output logic                  busy,
    output logic                  done,
    output logic                  error_len
);

    localparam int unsigned MAX_LEN = DEPTH * KEEP_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] last_ptr;
    logic [KEEP_WIDTH-1:0] last_keep;
    logic                  abort_pend;
    logic [47:0]           dest_r;
    logic [47:0]           src_r;
    logic [15:0]           type_r;

    logic                  len_ok;
    logic [15:0]           len_m1;
    logic [15:0]           len_rem;
    logic [ADDR_WIDTH-1:0] last_ptr_calc;
    logic                  is_last;
    logic                  pay_hs;
    logic                  frame_end;
    logic                  launch;

    // Byte enables for a final beat holding rem bytes (rem == 0 means a full beat).
    function automatic logic [KEEP_WIDTH-1:0] keep_from_rem(input logic [15:0] rem);
        logic [KEEP_WIDTH-1:0] k;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            k[i] = (rem == 16'd0) || (16'(i) < rem);
        end
        return k;
    endfunction

    assign len_ok        = (byte_len != 16'd0) && ({16'd0, byte_len} <= MAX_LEN);
    assign len_m1        = byte_len - 16'd1;
    assign len_rem       = byte_len % 16'(KEEP_WIDTH);
    assign last_ptr_calc = ADDR_WIDTH'(len_m1 / 16'(KEEP_WIDTH));
    assign launch        = (state == IDLE) && start && len_ok;

    assign is_last   = (rd_ptr == last_ptr);
    assign pay_hs    = (state == PAYLOAD) && m_eth_payload_axis_tready;
    // An abort flagged earlier turns whatever beat is presented into the final one.
    assign frame_end = pay_hs && (is_last || abort_pend);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (launch)          state_next = HDR;
            HDR:     if (m_eth_hdr_ready) state_next = PAYLOAD;
            PAYLOAD: if (frame_end)       state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    always_comb begin
        busy                      = (state != IDLE);
        m_eth_hdr_valid           = (state == HDR);
        m_eth_dest_mac            = dest_r;
        m_eth_src_mac             = src_r;
        m_eth_type                = type_r;
        m_eth_payload_axis_tvalid = 1'b0;
        m_eth_payload_axis_tdata  = '0;
        m_eth_payload_axis_tkeep  = '0;
        m_eth_payload_axis_tlast  = 1'b0;
        m_eth_payload_axis_tuser  = 1'b0;
        if (state == PAYLOAD) begin
            m_eth_payload_axis_tvalid = 1'b1;
            m_eth_payload_axis_tdata  = mem[rd_ptr];
            m_eth_payload_axis_tkeep  = is_last ? last_keep : '1;
            m_eth_payload_axis_tlast  = is_last || abort_pend;
            m_eth_payload_axis_tuser  = abort_pend;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            last_ptr   <= '0;
            last_keep  <= '0;
            abort_pend <= 1'b0;
            dest_r     <= '0;
            src_r      <= '0;
            type_r     <= '0;
            done       <= 1'b0;
            error_len  <= 1'b0;
        end else begin
            done      <= frame_end;
            error_len <= (state == IDLE) && start && !len_ok;

            if (launch) begin
                dest_r     <= dest_mac;
                src_r      <= src_mac;
                type_r     <= eth_type;
                last_ptr   <= last_ptr_calc;
                last_keep  <= keep_from_rem(len_rem);
                rd_ptr     <= '0;
                abort_pend <= 1'b0;
            end

            if (state == PAYLOAD) begin
                if (pay_hs) begin
                    rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                end
                // Abort on the true last beat's handshake ends the frame normally.
                if (frame_end) begin
                    abort_pend <= 1'b0;
                end else if (abort && !(pay_hs && is_last)) begin
                    abort_pend <= 1'b1;
                end
            end
        end
    end

    // Buffer is not reset; it is writable only while no frame is in flight.
    always_ff @(posedge clk) begin
        if (wr_en && (state == IDLE)) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_eth_frame_source.sv
// Directed bench for eth_frame_source (64-bit data, 16-word buffer).
module tb_eth_frame_source;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int DP = 16;
    localparam int AW = 4;

    localparam logic [47:0] DEST = 48'hDAD1D2D3D4D5;
    localparam logic [47:0] SRC  = 48'h5A5152535455;
    localparam logic [15:0] TYPE = 16'h0800;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic [47:0]   dest_mac = '0;
    logic [47:0]   src_mac = '0;
    logic [15:0]   eth_type = '0;
    logic [15:0]   byte_len = '0;
    logic          abort = 1'b0;
    logic          hdr_valid;
    logic          hdr_ready = 1'b0;
    logic [47:0]   o_dest;
    logic [47:0]   o_src;
    logic [15:0]   o_type;
    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic          tvalid;
    logic          tready = 1'b0;
    logic          tlast;
    logic          tuser;
    logic          busy;
    logic          done;
    logic          error_len;

    int tests_run = 0;
    int tests_failed = 0;

    // Capture of the most recent frame
    int            n_beats;
    logic [DW-1:0] cap_data [32];
    logic [KW-1:0] cap_keep [32];
    logic          cap_last [32];
    logic          cap_user [32];
    int            cap_cyc  [32];
    int            hdr_hs;
    int            hdr_cyc;
    logic [47:0]   hs_dest;
    logic [47:0]   hs_src;
    logic [15:0]   hs_type;
    int            stall_err;
    bit            timed_out;
    logic          done_seen;
    logic          busy_at_done;
    int            done_cyc;

    eth_frame_source #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .DEPTH      (DP),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .wr_en                     (wr_en),
        .wr_addr                   (wr_addr),
        .wr_data                   (wr_data),
        .start                     (start),
        .dest_mac                  (dest_mac),
        .src_mac                   (src_mac),
        .eth_type                  (eth_type),
        .byte_len                  (byte_len),
        .abort                     (abort),
        .m_eth_hdr_valid           (hdr_valid),
        .m_eth_hdr_ready           (hdr_ready),
        .m_eth_dest_mac            (o_dest),
        .m_eth_src_mac             (o_src),
        .m_eth_type                (o_type),
        .m_eth_payload_axis_tdata  (tdata),
        .m_eth_payload_axis_tkeep  (tkeep),
        .m_eth_payload_axis_tvalid (tvalid),
        .m_eth_payload_axis_tready (tready),
        .m_eth_payload_axis_tlast  (tlast),
        .m_eth_payload_axis_tuser  (tuser),
        .busy                      (busy),
        .done                      (done),
        .error_len                 (error_len)
    );

    always #5 clk = ~clk;

    // Buffer word i holds byte values 8*i .. 8*i+7, byte 0 in bits [7:0].
    function automatic logic [DW-1:0] exp_word(input int i);
        logic [DW-1:0] w;
        for (int b = 0; b < KW; b++) w[b*8 +: 8] = 8'(i * KW + b);
        return w;
    endfunction

    task automatic load_buffer();
        for (int i = 0; i < DP; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = exp_word(i);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
    endtask

    // Launches one frame and records every handshake; returns at the sample
    // one cycle after the final beat handshake (the cycle done should be high).
    task automatic run_frame(input logic [15:0] len, input int hdr_delay, input bit toggle,
                             input int abort_idx, input bit wr_during);
        int c; int wait_h; bit tog; bit last_hs;
        bit pt_stall; logic [DW-1:0] p_data; logic [KW-1:0] p_keep; logic p_last;
        bit ph_stall;
        n_beats = 0; hdr_hs = 0; hdr_cyc = -1; stall_err = 0;
        dest_mac = DEST; src_mac = SRC; eth_type = TYPE; byte_len = len; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 1; wait_h = 0; tog = 1'b1; last_hs = 1'b0; pt_stall = 1'b0; ph_stall = 1'b0;
        p_data = '0; p_keep = '0; p_last = 1'b0;
        while (!last_hs && c < 300) begin
            if (wr_during) begin wr_en = 1'b1; wr_addr = '0; wr_data = '1; end
            hdr_ready = (wait_h >= hdr_delay);
            tready = toggle ? tog : 1'b1;
            if (pt_stall && (!tvalid || tdata !== p_data || tkeep !== p_keep || tlast !== p_last))
                stall_err++;
            if (ph_stall && (!hdr_valid || o_dest !== DEST || o_src !== SRC || o_type !== TYPE))
                stall_err++;
            abort = (abort_idx >= 0) && tvalid && tready && (n_beats == abort_idx);
            if (hdr_valid) begin
                if (hdr_ready) begin
                    hdr_hs++; hdr_cyc = c; hs_dest = o_dest; hs_src = o_src; hs_type = o_type;
                end
                wait_h++;
            end
            ph_stall = hdr_valid && !hdr_ready;
            if (tvalid && tready && n_beats < 32) begin
                cap_data[n_beats] = tdata; cap_keep[n_beats] = tkeep;
                cap_last[n_beats] = tlast; cap_user[n_beats] = tuser;
                cap_cyc[n_beats]  = c;
                n_beats++;
                if (tlast) begin last_hs = 1'b1; wr_en = 1'b0; end
            end
            pt_stall = tvalid && !tready;
            p_data = tdata; p_keep = tkeep; p_last = tlast;
            if (tvalid) tog = !tog;
            @(posedge clk); #1;
            abort = 1'b0;
            c++;
        end
        wr_en = 1'b0;
        timed_out    = !last_hs;
        done_seen    = done;
        busy_at_done = busy;
        done_cyc     = c;
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if ({hdr_valid, tvalid, tlast, tuser, busy, done, error_len} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {hdr_valid, tvalid, tlast, tuser, busy, done, error_len});
        end
        tests_run++;
        if ({tdata, tkeep, o_dest, o_src, o_type} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: tdata=%h tkeep=%h dest=%h src=%h type=%h expected all 0",
                     tdata, tkeep, o_dest, o_src, o_type);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        load_buffer();
    endtask

    task automatic test_basic();
        run_frame(16'd28, 0, 1'b0, -1, 1'b0);
        tests_run++;
        if (timed_out || hdr_hs !== 1 || hdr_cyc !== 1) begin
            tests_failed++;
            $display("FAIL basic_hdr: timeout=%0d hs=%0d cyc=%0d expected 0 1 1", timed_out, hdr_hs, hdr_cyc);
        end
        tests_run++;
        if ({hs_dest, hs_src, hs_type} !== {DEST, SRC, TYPE}) begin
            tests_failed++;
            $display("FAIL basic_fields: got %h %h %h expected %h %h %h", hs_dest, hs_src, hs_type, DEST, SRC, TYPE);
        end
        tests_run++;
        if (n_beats !== 4 || {cap_keep[0], cap_keep[1], cap_keep[2], cap_keep[3]} !== 32'hFFFFFF0F) begin
            tests_failed++;
            $display("FAIL basic_keep: beats=%0d keep=%h %h %h %h expected 4 beats ff ff ff 0f",
                     n_beats, cap_keep[0], cap_keep[1], cap_keep[2], cap_keep[3]);
        end
        tests_run++;
        if ({cap_last[0], cap_last[1], cap_last[2], cap_last[3]} !== 4'b0001 ||
            {cap_user[0], cap_user[1], cap_user[2], cap_user[3]} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL basic_last: last=%b%b%b%b user=%b%b%b%b expected 0001 0000",
                     cap_last[0], cap_last[1], cap_last[2], cap_last[3],
                     cap_user[0], cap_user[1], cap_user[2], cap_user[3]);
        end
        tests_run++;
        if (cap_cyc[0] !== 2 || cap_cyc[3] !== 5) begin
            tests_failed++;
            $display("FAIL basic_timing: first beat cyc=%0d last beat cyc=%0d expected 2 5", cap_cyc[0], cap_cyc[3]);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (cap_data[i] !== exp_word(i)) begin
                tests_failed++;
                $display("FAIL basic_data[%0d]: got %h expected %h", i, cap_data[i], exp_word(i));
            end
        end
        tests_run++;
        if (done_seen !== 1'b1 || busy_at_done !== 1'b0 || done_cyc !== 6) begin
            tests_failed++;
            $display("FAIL basic_done: done=%b busy=%b cyc=%0d expected 1 0 6", done_seen, busy_at_done, done_cyc);
        end
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_done_pulse: done=%b one cycle later, expected 0", done);
        end
    endtask

    task automatic test_back_to_back();
        run_frame(16'd32, 0, 1'b0, -1, 1'b0);
        tests_run++;
        if (n_beats !== 4 || cap_keep[3] !== 8'hFF || {cap_last[0], cap_last[1], cap_last[2], cap_last[3]} !== 4'b0001) begin
            tests_failed++;
            $display("FAIL len32: beats=%0d keep3=%h last3=%b expected 4 ff 1", n_beats, cap_keep[3], cap_last[3]);
        end
        tests_run++;
        if (done_seen !== 1'b1) begin
            tests_failed++;
            $display("FAIL len32_done: done=%b expected 1", done_seen);
        end
        // start issued in the done cycle must be accepted immediately
        run_frame(16'd1, 0, 1'b0, -1, 1'b0);
        tests_run++;
        if (hdr_cyc !== 1) begin
            tests_failed++;
            $display("FAIL b2b_accept: header cycle=%0d expected 1", hdr_cyc);
        end
        tests_run++;
        if (n_beats !== 1 || cap_keep[0] !== 8'h01 || cap_last[0] !== 1'b1 || cap_data[0] !== exp_word(0)) begin
            tests_failed++;
            $display("FAIL len1: beats=%0d keep=%h last=%b data=%h expected 1 01 1 %h",
                     n_beats, cap_keep[0], cap_last[0], cap_data[0], exp_word(0));
        end
    endtask

    task automatic test_backpressure();
        run_frame(16'd28, 3, 1'b1, -1, 1'b0);
        tests_run++;
        if (timed_out || hdr_hs !== 1 || hdr_cyc !== 4) begin
            tests_failed++;
            $display("FAIL bp_hdr: timeout=%0d hs=%0d cyc=%0d expected 0 1 4", timed_out, hdr_hs, hdr_cyc);
        end
        tests_run++;
        if (stall_err !== 0) begin
            tests_failed++;
            $display("FAIL bp_stable: %0d outputs changed during stall, expected 0", stall_err);
        end
        tests_run++;
        if (n_beats !== 4 || cap_cyc[0] !== 5 || cap_cyc[3] !== 11) begin
            tests_failed++;
            $display("FAIL bp_beats: beats=%0d first=%0d last=%0d expected 4 5 11", n_beats, cap_cyc[0], cap_cyc[3]);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (cap_data[i] !== exp_word(i) || cap_keep[i] !== ((i == 3) ? 8'h0F : 8'hFF)) begin
                tests_failed++;
                $display("FAIL bp_data[%0d]: got %h/%h expected %h/%h", i, cap_data[i], cap_keep[i],
                         exp_word(i), (i == 3) ? 8'h0F : 8'hFF);
            end
        end
    endtask

    task automatic test_len_error();
        logic [15:0] bad [2];
        bad[0] = 16'd0;
        bad[1] = 16'd129;
        for (int k = 0; k < 2; k++) begin
            byte_len = bad[k]; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            tests_run++;
            if (error_len !== 1'b1 || hdr_valid !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL len_err_%0d: err=%b hdr=%b busy=%b expected 1 0 0", bad[k], error_len, hdr_valid, busy);
            end
            @(posedge clk); #1;
            tests_run++;
            if (error_len !== 1'b0 || hdr_valid !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL len_err_pulse_%0d: err=%b hdr=%b busy=%b expected 0 0 0", bad[k], error_len, hdr_valid, busy);
            end
        end
        run_frame(16'd128, 0, 1'b0, -1, 1'b0);
        tests_run++;
        if (timed_out || n_beats !== 16 || cap_keep[15] !== 8'hFF || cap_last[15] !== 1'b1 || cap_last[14] !== 1'b0) begin
            tests_failed++;
            $display("FAIL len128: beats=%0d keep15=%h last14/15=%b%b expected 16 ff 01",
                     n_beats, cap_keep[15], cap_last[14], cap_last[15]);
        end
        for (int i = 0; i < 16; i++) begin
            tests_run++;
            if (cap_data[i] !== exp_word(i)) begin
                tests_failed++;
                $display("FAIL len128_data[%0d]: got %h expected %h", i, cap_data[i], exp_word(i));
            end
        end
    endtask

    task automatic test_abort();
        run_frame(16'd64, 0, 1'b0, 1, 1'b1);
        tests_run++;
        if (timed_out || n_beats !== 3) begin
            tests_failed++;
            $display("FAIL abort_beats: timeout=%0d beats=%0d expected 0 3", timed_out, n_beats);
        end
        tests_run++;
        if ({cap_last[0], cap_last[1], cap_last[2]} !== 3'b001 ||
            {cap_user[0], cap_user[1], cap_user[2]} !== 3'b001 || cap_keep[2] !== 8'hFF) begin
            tests_failed++;
            $display("FAIL abort_flags: last=%b%b%b user=%b%b%b keep2=%h expected 001 001 ff",
                     cap_last[0], cap_last[1], cap_last[2], cap_user[0], cap_user[1], cap_user[2], cap_keep[2]);
        end
        tests_run++;
        if (done_seen !== 1'b1 || busy_at_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_done: done=%b busy=%b expected 1 0", done_seen, busy_at_done);
        end
        run_frame(16'd8, 0, 1'b0, -1, 1'b0);
        tests_run++;
        if (n_beats !== 1 || cap_data[0] !== exp_word(0) || cap_keep[0] !== 8'hFF || cap_user[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_buffer: beats=%0d data=%h keep=%h user=%b expected 1 %h ff 0",
                     n_beats, cap_data[0], cap_keep[0], cap_user[0], exp_word(0));
        end
    endtask

    task automatic test_async_reset();
        dest_mac = DEST; src_mac = SRC; eth_type = TYPE; byte_len = 16'd64;
        hdr_ready = 1'b1; tready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        tests_run++;
        if (tvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL arst_pre: tvalid=%b before reset, expected 1", tvalid);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({tvalid, busy, hdr_valid, tlast} !== 4'b0 || tdata !== '0) begin
            tests_failed++;
            $display("FAIL arst_clear: tvalid=%b busy=%b hdr=%b tlast=%b tdata=%h expected all 0",
                     tvalid, busy, hdr_valid, tlast, tdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        tests_run++;
        if ({tvalid, busy, hdr_valid} !== 3'b0) begin
            tests_failed++;
            $display("FAIL arst_no_resume: tvalid=%b busy=%b hdr=%b expected 0 0 0", tvalid, busy, hdr_valid);
        end
        run_frame(16'd28, 0, 1'b0, -1, 1'b0);
        tests_run++;
        if (timed_out || n_beats !== 4 || cap_keep[3] !== 8'h0F) begin
            tests_failed++;
            $display("FAIL arst_replay: timeout=%0d beats=%0d keep3=%h expected 0 4 0f", timed_out, n_beats, cap_keep[3]);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (cap_data[i] !== exp_word(i)) begin
                tests_failed++;
                $display("FAIL arst_data[%0d]: got %h expected %h", i, cap_data[i], exp_word(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_len_error();
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/eth_frame_source.md
# eth_frame_source

Parametrised, synthesisable Ethernet frame source that replays a preloaded frame onto an Ethernet header + AXI-stream payload interface, such as the `s_eth_*` slave port of `udp_complete_64`. It generalises the bench's hand-sequenced frame driver to:

- any data width and payload buffer depth;
- full valid/ready backpressure;
- last-beat `tkeep` computed from byte length;
- length checking and mid-frame abort.

It sits between a loader (bench sequencer or CPU register file) and the Ethernet RX side of the UDP/IP stack.

## Interface
Parameters:
- DATA_WIDTH, 64, payload bus width in bits; must be a multiple of 8, from 8 to 512.
- KEEP_WIDTH, DATA_WIDTH/8, bytes per beat.
- DEPTH, 16, payload buffer size in words; must be a power of two.
- ADDR_WIDTH, $clog2(DEPTH), width of the word address.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- wr_en  in  1  payload buffer write strobe.
- wr_addr  in  ADDR_WIDTH  payload word address.
- wr_data  in  DATA_WIDTH  payload word; byte 0 is bits [7:0].
- start  in  1  frame launch request.
- dest_mac  in  48  header field, latched on start.
- src_mac  in  48  header field, latched on start.
- eth_type  in  16  header field, latched on start.
- byte_len  in  16  payload length in bytes, latched on start.
- abort  in  1  truncate the frame in progress.
- m_eth_hdr_valid  out  1  header valid.
- m_eth_hdr_ready  in  1  header ready.
- m_eth_dest_mac  out  48  latched destination MAC.
- m_eth_src_mac  out  48  latched source MAC.
- m_eth_type  out  16  latched EtherType.
- m_eth_payload_axis_tdata  out  DATA_WIDTH  payload data.
- m_eth_payload_axis_tkeep  out  KEEP_WIDTH  byte enables.
- m_eth_payload_axis_tvalid  out  1  payload valid.
- m_eth_payload_axis_tready  in  1  payload ready.
- m_eth_payload_axis_tlast  out  1  last beat of frame.
- m_eth_payload_axis_tuser  out  1  bad-frame marker; set only on an aborted last beat.
- busy  out  1  high in HDR and PAYLOAD.
- done  out  1  one-cycle pulse after the final beat is accepted.
- error_len  out  1  one-cycle pulse when start is rejected.

## Operation
State machine: IDLE, HDR, PAYLOAD.
- **IDLE**
  - Let MAX = DEPTH*KEEP_WIDTH. On start with 1 ≤ byte_len ≤ MAX: latch the header fields and byte_len, set beats = ceil(byte_len/KEEP_WIDTH), reset rd_ptr to 0, go to HDR.
  - On start with byte_len = 0 or byte_len > MAX: pulse error_len and stay in IDLE.
- **HDR**
  - m_eth_hdr_valid = 1; header fields held stable.
  - On hdr_valid & hdr_ready: go to PAYLOAD.
- **PAYLOAD**
  - Outputs: tvalid = 1, tdata = buffer[rd_ptr].
  - tkeep = all ones, except on the last beat: if rem = byte_len mod KEEP_WIDTH ≠ 0, tkeep = (1<<rem)−1.
  - tlast = 1 when rd_ptr = beats−1.
  - Each tvalid & tready advances rd_ptr. Handshake of the tlast beat: go to IDLE and pulse done.
- **Buffer writes**
  - wr_en is honoured only in IDLE and ignored while busy.
  - Buffer contents are not cleared by reset or by frame end; a frame can be replayed with another start.
- **abort**
  - Ignored in IDLE and HDR.
  - In PAYLOAD: from the next cycle, the beat currently presented (not yet accepted) carries tlast = 1, tuser = 1, and the normal tkeep for its position.
  - Its handshake ends the frame (IDLE, done pulse).
  - If abort coincides with the handshake of a non-last beat, the following beat becomes the terminating beat.
  - If abort coincides with the handshake of the true last beat, the frame ends normally with tuser = 0.
- **start**
  - Ignored while busy.
  - start and abort in the same IDLE cycle: start wins.

## Timing
- Reset values, applied asynchronously: all valid/tlast/tuser/busy/done/error_len = 0; header, tdata and tkeep = 0; state IDLE.
- Reset mid-frame clears outputs immediately. No partial frame resumes after reset release.
- start at edge N → hdr_valid = 1 from N+1.
- Header handshake at edge H → tvalid = 1 with beat 0 from H+1. There is no bubble between payload beats while tready stays high.
- Latency from start to the first beat is 2 cycles with ready held high.
- done is asserted in the cycle after the last-beat handshake; busy falls in that same cycle.
- hdr_valid and tvalid never drop without a handshake. tdata, tkeep and tlast stay stable while stalled; only tlast/tuser change, and only on abort.
- A new start is accepted in the same cycle as done. Frame-to-frame gap is 1 cycle.

## Test plan
1. DATA_WIDTH=64, byte_len=28, dest DAD1D2D3D4D5, src 5A5152535455, type 0800, all readies high → 1 header handshake, then 4 consecutive beats. tkeep FF, FF, FF, 0F; tlast only on beat 4; done pulses 1 cycle later.
2. byte_len=32 → 4 beats, last tkeep FF. byte_len=1 → single beat with tkeep 01 and tlast=1.
3. Same 28-byte frame with tready toggling 1,0,1,0 and hdr_ready delayed 3 cycles → tdata/tkeep held during stalls, no beat lost or duplicated, all 28 bytes match the buffer.
4. DEPTH=16, start with byte_len=0 and then 129 → error_len pulses each time, hdr_valid stays 0, busy stays 0. byte_len=128 → accepted, 16 beats.
5. 64-byte frame, abort asserted for one cycle after beat 2 is accepted → beat 3 has tlast=1, tuser=1, tkeep FF; done follows. wr_en during the frame leaves the buffer unchanged.
6. rst asserted mid-payload between clock edges → tvalid, busy and hdr_valid go to 0 without waiting for a clock edge. After release, start replays the same buffer contents correctly.
